// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of dram_control: one transaction at a time,
// with a DONE cycle so a requester dropping valid after ready is never re-granted.
module dram_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic              p0_wmask,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic              p1_wmask,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wmask,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e              state_q, state_d;
   logic                last_q, last_d;   // 1 = port 1 was granted last
   logic                gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wmask_q, wmask_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                grant;

   // On a tie the port not granted last wins; a lone requester always wins.
   always_comb begin
      grant = p1_valid;
      if (p0_valid && p1_valid) begin
         grant = ~last_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wmask_d   = wmask_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      mem_valid = 1'b0;
      p0_ready  = 1'b0;
      p1_ready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (p0_valid || p1_valid) begin
               state_d = StBusy;
               gnt_d   = grant;
               last_d  = grant;
               addr_d  = grant ? p1_addr  : p0_addr;
               wmask_d = grant ? p1_wmask : p0_wmask;
               wdata_d = grant ? p1_wdata : p0_wdata;
            end
         end
         StBusy: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               state_d = StDone;
               if (!wmask_q) begin
                  rdata_d = mem_rdata;
               end
            end
         end
         StDone: begin
            p0_ready = ~gnt_q;
            p1_ready = gnt_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         addr_q  <= '0;
         wmask_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         wmask_q <= wmask_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wmask = wmask_q;
   assign mem_wdata = wdata_q;
   assign p0_rdata  = rdata_q;
   assign p1_rdata  = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios then randomized traffic, checked against a
// transaction-level model (round-robin pointer, pending set, last read value).
module tb_dram_arbiter;

   logic         clk = 1'b0;
   logic         rstn;
   logic         p0_valid, p0_ready, p0_wmask;
   logic [31:0]  p0_addr;
   logic [127:0] p0_wdata, p0_rdata;
   logic         p1_valid, p1_ready, p1_wmask;
   logic [31:0]  p1_addr;
   logic [127:0] p1_wdata, p1_rdata;
   logic         mem_valid, mem_ready, mem_wmask;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;

   dram_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .p0_valid  (p0_valid),
      .p0_ready  (p0_ready),
      .p0_addr   (p0_addr),
      .p0_wmask  (p0_wmask),
      .p0_wdata  (p0_wdata),
      .p0_rdata  (p0_rdata),
      .p1_valid  (p1_valid),
      .p1_ready  (p1_ready),
      .p1_addr   (p1_addr),
      .p1_wmask  (p1_wmask),
      .p1_wdata  (p1_wdata),
      .p1_rdata  (p1_rdata),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial forever #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit           pend [2];
   logic [31:0]  a    [2];
   bit           w    [2];
   logic [127:0] wd   [2];
   int           last   = 1;
   logic [127:0] exp_rd = '0;

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive();
      p0_valid = pend[0]; p0_addr = a[0]; p0_wmask = w[0]; p0_wdata = wd[0];
      p1_valid = pend[1]; p1_addr = a[1]; p1_wmask = w[1]; p1_wdata = wd[1];
   endtask

   task automatic set_req(input int p, input logic [31:0] addr, input bit wr,
                          input logic [127:0] data);
      pend[p] = 1'b1; a[p] = addr; w[p] = wr; wd[p] = data;
      drive();
   endtask

   task automatic new_req(input int p);
      set_req(p, $urandom(), 1'($urandom_range(0, 1)), rnd128());
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = rnd128();
         @(negedge clk);
         chk("idle_mem_valid", mem_valid, 0);
         chk("idle_p0_ready", p0_ready, 0);
         chk("idle_p1_ready", p1_ready, 0);
      end
      mem_ready = 1'b0;
   endtask

   // Called at a negedge in IDLE with requests driven; serves until nothing is pending.
   task automatic serve(input int dly, input bit fix_rd, input logic [127:0] rd_fix,
                        input int max_new);
      int g, d, nn;
      logic [127:0] rd;
      nn = max_new;
      while (pend[0] || pend[1]) begin
         g    = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
         last = g;
         d    = (dly < 0) ? $urandom_range(0, 4) : dly;
         rd   = fix_rd ? rd_fix : rnd128();
         @(negedge clk);
         for (int i = 0; i <= d; i++) begin
            chk("busy_mem_valid", mem_valid, 1);
            chk("busy_mem_addr", mem_addr, a[g]);
            chk("busy_mem_wmask", mem_wmask, w[g]);
            chk("busy_mem_wdata", mem_wdata, wd[g]);
            chk("busy_ready", {p1_ready, p0_ready}, 0);
            if (nn > 0 && !pend[1-g] && $urandom_range(0, 2) == 0) begin
               new_req(1 - g);
               nn--;
            end
            mem_ready = (i == d);
            mem_rdata = (i == d) ? rd : rnd128();
            @(negedge clk);
         end
         // DONE cycle; a stray mem_ready here must be ignored
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = rnd128();
         if (!w[g]) exp_rd = rd;
         chk("done_p0_ready", p0_ready, (g == 0));
         chk("done_p1_ready", p1_ready, (g == 1));
         chk("done_mem_valid", mem_valid, 0);
         chk("done_p0_rdata", p0_rdata, exp_rd);
         chk("done_p1_rdata", p1_rdata, exp_rd);
         @(negedge clk);
         chk("post_mem_valid", mem_valid, 0);
         chk("post_ready", {p1_ready, p0_ready}, 0);
         // Requester drops valid one cycle after ready
         pend[g] = 1'b0;
         drive();
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = rnd128();
      end
   endtask

   initial begin
      int sel;
      pend[0] = 0; pend[1] = 0;
      a[0] = '0; a[1] = '0; w[0] = 0; w[1] = 0; wd[0] = '0; wd[1] = '0;
      drive();
      mem_ready = 1'b0;
      mem_rdata = '0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_ready", {p1_ready, p0_ready}, 0);
      chk("rst_rdata", p0_rdata, 0);
      rstn = 1'b1;

      // Single read on port 0, completion after five BUSY cycles
      set_req(0, 32'h100, 1'b0, '0);
      serve(4, 1'b1, 128'h0123456789abcdefdeadbeefabad1dea, 0);
      idle_check(2);

      // Ties from a fresh reset: p0, p1, p0, p1
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1; last = 1; exp_rd = '0;
      set_req(0, 32'h200, 1'b0, '0);
      set_req(1, 32'h300, 1'b0, '0);
      serve(-1, 1'b0, '0, 0);
      set_req(0, 32'h400, 1'b0, '0);
      set_req(1, 32'h500, 1'b0, '0);
      serve(-1, 1'b0, '0, 0);

      // Write on port 1 keeps the prior read value visible
      set_req(1, 32'h600, 1'b1, 128'hdeadbeef);
      serve(3, 1'b1, 128'hfeedface, 0);

      // Reset while BUSY abandons the transaction
      mem_ready = 1'b0;
      set_req(1, 32'h700, 1'b0, '0);
      @(negedge clk);
      chk("rbusy_mem_valid", mem_valid, 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rbusy_after_mem_valid", mem_valid, 0);
      chk("rbusy_after_ready", {p1_ready, p0_ready}, 0);
      chk("rbusy_after_rdata", p1_rdata, 0);
      rstn = 1'b1; last = 1; exp_rd = '0;
      pend[1] = 1'b0;
      drive();
      idle_check(3);
      set_req(0, 32'h800, 1'b0, '0);
      set_req(1, 32'h900, 1'b1, rnd128());
      serve(-1, 1'b0, '0, 0);

      // Spurious mem_ready in IDLE
      mem_ready = 1'b1;
      mem_rdata = rnd128();
      idle_check(4);

      // Randomized traffic with requests arriving mid-transaction
      for (int r = 0; r < 60; r++) begin
         sel = $urandom_range(1, 3);
         if (sel[0]) new_req(0);
         if (sel[1]) new_req(1);
         serve(-1, 1'b0, '0, 2);
         if ($urandom_range(0, 3) == 0) idle_check(2);
      end
      idle_check(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
